// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
//   Refills one cache block from a multi-cycle main memory after a lookup miss.
//   Issues one read per word on consecutive cycles, writes each returned word
//   into the data array, then pulses the tag write and fill_done for one cycle.
//
// Ports
//   clk                rising-edge clock
//   rst                asynchronous reset, active low
//   miss_detected      lookup missed; held by requester until fill_done
//   miss_address       byte address that missed; sampled on the start edge only
//   memory_data_valid  one returned word this cycle
//   memory_data        returned word
//   fsm_busy           fill in progress (FILL or DONE)
//   mem_req            read request this cycle
//   memory_address     request address, valid with mem_req
//   write_data_array   write data_out into the data array at word_index
//   word_index         word slot inside the block for the current write
//   data_out           word to write (pass-through of memory_data)
//   write_tag_array    one-cycle tag/valid write pulse
//   fill_done          one-cycle completion pulse
module cache_fill_fsm #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 16,
  parameter int WORDS  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     miss_detected,
  input  logic [AWIDTH-1:0]        miss_address,
  input  logic                     memory_data_valid,
  input  logic [DWIDTH-1:0]        memory_data,
  output logic                     fsm_busy,
  output logic                     mem_req,
  output logic [AWIDTH-1:0]        memory_address,
  output logic                     write_data_array,
  output logic [$clog2(WORDS)-1:0] word_index,
  output logic [DWIDTH-1:0]        data_out,
  output logic                     write_tag_array,
  output logic                     fill_done
);

  localparam int IW = $clog2(WORDS);
  localparam int CW = IW + 1;
  localparam logic [AWIDTH-1:0] OFF_MASK = AWIDTH'(2 * WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DONE
  } state_t;

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] base;
  logic [CW-1:0]     req_cnt;
  logic [CW-1:0]     rcv_cnt;
  logic              req_active;
  logic              beat_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      base    <= '0;
      req_cnt <= '0;
      rcv_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (miss_detected) begin
          base    <= miss_address & ~OFF_MASK;
          req_cnt <= '0;
          rcv_cnt <= '0;
        end
      end else begin
        if (req_active) begin
          req_cnt <= req_cnt + CW'(1);
        end
        if (beat_accept) begin
          rcv_cnt <= rcv_cnt + CW'(1);
        end
      end
    end
  end

  // Outputs are gated by their qualifiers so every output reads 0 outside an
  // active request/beat, including while reset holds the FSM in IDLE.
  always_comb begin
    state_nxt        = state;
    req_active       = (state == FILL) && (req_cnt < CW'(WORDS));
    beat_accept      = (state == FILL) && memory_data_valid && (rcv_cnt < CW'(WORDS));
    fsm_busy         = (state != IDLE);
    mem_req          = req_active;
    memory_address   = '0;
    write_data_array = beat_accept;
    word_index       = '0;
    data_out         = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    if (req_active) begin
      memory_address = base + (AWIDTH'(req_cnt) << 1);
    end
    if (beat_accept) begin
      word_index = rcv_cnt[IW-1:0];
      data_out   = memory_data;
    end

    case (state)
      IDLE: begin
        if (miss_detected) begin
          state_nxt = FILL;
        end
      end
      FILL: begin
        if (beat_accept && (rcv_cnt == CW'(WORDS - 1))) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_nxt       = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Scoreboard bench for cache_fill_fsm: stimulus pushes expected requests,
// writes and completion pulses (with their cycle numbers); a negedge monitor
// pops and compares whenever the DUT presents one. A memory model returns
// each requested word L cycles later, with optional gaps between beats.
module tb_cache_fill_fsm;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int WORDS = 8;
  localparam int L     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          miss_detected = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic          memory_data_valid = 1'b0;
  logic [DW-1:0] memory_data = '0;
  logic          fsm_busy;
  logic          mem_req;
  logic [AW-1:0] memory_address;
  logic          write_data_array;
  logic [2:0]    word_index;
  logic [DW-1:0] data_out;
  logic          write_tag_array;
  logic          fill_done;

  cache_fill_fsm #(.AWIDTH(AW), .DWIDTH(DW), .WORDS(WORDS)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_req           (mem_req),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_index        (word_index),
    .data_out          (data_out),
    .write_tag_array   (write_tag_array),
    .fill_done         (fill_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct { int cyc; logic [15:0] addr; } req_t;
  typedef struct { int cyc; logic [2:0] idx; logic [15:0] data; } wr_t;
  typedef struct { int due; logic [15:0] addr; } mem_t;

  req_t exp_req[$];
  wr_t  exp_wr[$];
  int   exp_done[$];
  mem_t mem_q[$];

  logic inject_stray = 1'b0;
  int   gap_after[9] = '{default: 0};

  int nom_wr[8] = '{5, 6, 7, 8, 9, 10, 11, 12};
  int bub_wr[8] = '{5, 6, 7, 10, 11, 12, 14, 15};

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 | (a & 16'h0FFF);
  endfunction

  function automatic logic [63:0] all_outs();
    return {24'd0, fsm_busy, mem_req, memory_address, write_data_array,
            word_index, data_out, write_tag_array, fill_done};
  endfunction

  // Monitor / scoreboard
  req_t mon_r;
  wr_t  mon_w;
  int   mon_d;
  mem_t mon_m;
  always @(negedge clk) begin
    if (mem_req) begin
      mon_m.due  = cyc + L;
      mon_m.addr = memory_address;
      mem_q.push_back(mon_m);
      checks++;
      if (exp_req.size() == 0) begin
        failures++;
        $display("FAIL req_unexpected cycle=%0d got addr=%h expected no request", cyc, memory_address);
      end else begin
        mon_r = exp_req.pop_front();
        if (mon_r.cyc != cyc || mon_r.addr != memory_address) begin
          failures++;
          $display("FAIL req cycle=%0d got addr=%h expected cycle=%0d addr=%h",
                   cyc, memory_address, mon_r.cyc, mon_r.addr);
        end
      end
    end
    if (write_data_array) begin
      checks++;
      if (exp_wr.size() == 0) begin
        failures++;
        $display("FAIL write_unexpected cycle=%0d got idx=%0d data=%h expected no write",
                 cyc, word_index, data_out);
      end else begin
        mon_w = exp_wr.pop_front();
        if (mon_w.cyc != cyc || mon_w.idx != word_index || mon_w.data != data_out) begin
          failures++;
          $display("FAIL write cycle=%0d got idx=%0d data=%h expected cycle=%0d idx=%0d data=%h",
                   cyc, word_index, data_out, mon_w.cyc, mon_w.idx, mon_w.data);
        end
      end
    end
    if (fill_done || write_tag_array) begin
      checks++;
      if (exp_done.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cycle=%0d got done=%b tag=%b expected none",
                 cyc, fill_done, write_tag_array);
      end else begin
        mon_d = exp_done.pop_front();
        if (mon_d != cyc || !fill_done || !write_tag_array || !fsm_busy) begin
          failures++;
          $display("FAIL done cycle=%0d got done=%b tag=%b busy=%b expected cycle=%0d all 1",
                   cyc, fill_done, write_tag_array, fsm_busy, mon_d);
        end
      end
    end
  end

  // Memory model: returns each request L cycles later, in order.
  int   mem_wait = 0;
  int   mem_beat = 0;
  mem_t drv_m;
  always @(posedge clk) begin
    #2;
    memory_data_valid = 1'b0;
    memory_data       = '0;
    if (inject_stray) begin
      memory_data_valid = 1'b1;
      memory_data       = 16'hDEAD;
    end else if (mem_wait > 0) begin
      mem_wait--;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      drv_m = mem_q.pop_front();
      memory_data_valid = 1'b1;
      memory_data       = mem_word(drv_m.addr);
      mem_beat++;
      mem_wait = (mem_beat <= 8) ? gap_after[mem_beat] : 0;
    end
    if (mem_q.size() == 0) mem_beat = 0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic run_fill(input logic [15:0] addr, input int wr_rel[8], input int done_rel,
                          input int drop_rel, input logic [15:0] addr_change);
    int          s;
    logic [15:0] base;
    req_t        r;
    wr_t         w;
    base = addr & 16'hFFF0;
    s    = cyc;
    for (int i = 0; i < WORDS; i++) begin
      r.cyc  = s + 1 + i;
      r.addr = base + 16'(2 * i);
      exp_req.push_back(r);
      w.cyc  = s + wr_rel[i];
      w.idx  = 3'(i);
      w.data = mem_word(base + 16'(2 * i));
      exp_wr.push_back(w);
    end
    exp_done.push_back(s + done_rel);
    miss_detected = 1'b1;
    miss_address  = addr;
    step();
    chk("busy_cycle1", 64'(fsm_busy), 64'd1);
    miss_address = addr_change;
    while (cyc < s + drop_rel) step();
    miss_detected = 1'b0;
    chk("busy_at_drop", 64'(fsm_busy), 64'(drop_rel <= done_rel));
    while (cyc < s + done_rel + 1) step();
    chk("idle_after_done", all_outs(), 64'd0);
    chk("fill_drained", 64'(exp_req.size() + exp_wr.size() + exp_done.size()), 64'd0);
  endtask

  initial begin
    int   s;
    req_t r;
    wr_t  w;

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      miss_detected = 1'($urandom);
      miss_address  = 16'($urandom);
      inject_stray  = 1'($urandom);
      #3;
      chk("reset_outs", all_outs(), 64'd0);
    end
    step();
    miss_detected = 1'b0;
    inject_stray  = 1'b0;
    rst           = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      #3;
      chk("post_reset_idle", all_outs(), 64'd0);
    end
    step();

    // Nominal fill
    run_fill(16'h1236, nom_wr, 13, 14, 16'h1236);
    step();

    // Bubbled returns
    gap_after[3] = 2;
    gap_after[6] = 1;
    run_fill(16'h3C0A, bub_wr, 16, 17, 16'h3C0A);
    gap_after[3] = 0;
    gap_after[6] = 0;
    step();

    // Stray beats in IDLE, then a fill whose requester drops early
    for (int i = 0; i < 2; i++) begin
      inject_stray = 1'b1;
      step();
      #3;
      chk("stray_valid_present", 64'(memory_data_valid), 64'd1);
      chk("stray_ignored", all_outs(), 64'd0);
      inject_stray = 1'b0;
      step();
    end
    step();
    run_fill(16'h2468, nom_wr, 13, 3, 16'h5555);
    step();

    // Reset mid-fill
    s = cyc;
    for (int i = 0; i < 5; i++) begin
      r.cyc  = s + 1 + i;
      r.addr = 16'h7770 + 16'(2 * i);
      exp_req.push_back(r);
    end
    w.cyc  = s + 5;
    w.idx  = 3'd0;
    w.data = mem_word(16'h7770);
    exp_wr.push_back(w);
    miss_detected = 1'b1;
    miss_address  = 16'h777C;
    while (cyc < s + 6) step();
    #2;
    rst = 1'b0;
    #1;
    chk("reset_async_outs", all_outs(), 64'd0);
    chk("pre_reset_drained", 64'(exp_req.size() + exp_wr.size()), 64'd0);
    exp_req.delete();
    exp_wr.delete();
    exp_done.delete();
    miss_detected = 1'b0;
    step();
    step();
    rst = 1'b1;
    #3;
    chk("late_beat_valid", 64'(memory_data_valid), 64'd1);
    chk("late_beat_ignored", all_outs(), 64'd0);
    for (int i = 0; i < 4; i++) step();
    chk("late_beats_consumed", 64'(mem_q.size()), 64'd0);
    run_fill(16'hFFFE, nom_wr, 13, 14, 16'hFFFE);
    step();

    // Back-to-back misses
    run_fill(16'h0040, nom_wr, 13, 14, 16'h0040);
    step();
    run_fill(16'h0100, nom_wr, 13, 14, 16'h0100);

    for (int i = 0; i < 5; i++) step();
    chk("final_queues_empty", 64'(exp_req.size() + exp_wr.size() + exp_done.size() + mem_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog cycle=%0d got=timeout expected=completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
